// File: rtl/bit_fill.sv
// Sequential mask generator: sets exactly clamp(count_i) bits of out_o, one bit per clock.
// Define BIT_FILL_MSB_EN to fill from the MSB end instead of the LSB end.
//
// state | meaning
// IDLE  | waiting for go_i, out_o holds 0 after reset
// FILL  | inserting one 1-bit per cycle until ctr_q reaches 0
// DONE  | out_o holds the result; go_i restarts immediately
module bit_fill #(
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           go_i,
    input  logic [$clog2(WIDTH+1)-1:0]     count_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [WIDTH-1:0]               out_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [CW-1:0]    ctr_q, ctr_d;
    logic [CW-1:0]    count_clamped;
    logic [WIDTH-1:0] fill_step;

    // count_i can encode values above WIDTH; never shift more than WIDTH times
    assign count_clamped = (count_i > WIDTH_C) ? WIDTH_C : count_i;

`ifdef BIT_FILL_MSB_EN
    assign fill_step = {1'b1, vec_q[WIDTH-1:1]};
`else
    assign fill_step = {vec_q[WIDTH-2:0], 1'b1};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ctr_q   <= ctr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ctr_d   = ctr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (go_i) begin
                    state_d = FILL;
                    vec_d   = '0;
                    ctr_d   = count_clamped;
                end
            end
            FILL: begin
                if (ctr_q != '0) begin
                    vec_d = fill_step;
                    ctr_d = ctr_q - CW'(1);
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == FILL);
        done_o = (state_q == DONE);
    end

    assign out_o = vec_q;

endmodule

// File: tb/tb_bit_fill.sv
// Scoreboard bench for bit_fill (WIDTH=8): driver queues expected results, a negedge monitor checks each done.
module tb_bit_fill;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         go_i;
    logic [3:0]   count_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] out_o;

    bit_fill #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .go_i    (go_i),
        .count_i (count_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .out_o   (out_o)
    );

    typedef struct {
        logic [W-1:0] vec;
        int           k;
        int           goedge;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    logic done_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_vec(input int k);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < k; i++) begin
`ifdef BIT_FILL_MSB_EN
            v[W-1-i] = 1'b1;
`else
            v[i] = 1'b1;
`endif
        end
        return v;
    endfunction

    // Monitor: one scoreboard entry per rising edge of done_o
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (busy_o) busy_cnt++;
            if (done_o && !done_prev) begin
                chk("sb_nonempty_at_done", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out", int'(out_o), int'(e.vec));
                    chk("latency", cyc - e.goedge, e.k + 1);
                    chk("busy_cycles", busy_cnt, e.k + 1);
                    chk("roundtrip_popcount", $countones(out_o), e.k);
                    if (busy_o) chk("busy_done_exclusive", 1, 0);
                end
                busy_cnt = 0;
            end
            done_prev = done_o;
        end
    end

    // Issue go for one cycle at a negedge; returns 1 time unit after the sampling edge
    task automatic start(input int c);
        exp_t e;
        @(negedge clk);
        go_i    = 1'b1;
        count_i = 4'(c);
        e.k      = (c > W) ? W : c;
        e.vec    = exp_vec(e.k);
        e.goedge = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        go_i = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 60) begin
            @(negedge clk);
            #2;
            i++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        rst     = 1'b1;
        go_i    = 1'b0;
        count_i = '0;
        #2;
        chk("reset_out", int'(out_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_done", int'(done_o), 0);
        @(negedge clk);
        #1 rst = 1'b0;

        start(3);
        wait_idle();
        start(0);
        wait_idle();
        start(8);
        wait_idle();
        start(15);
        wait_idle();

        // Back-to-back restart from DONE, with ignored go pulses during FILL
        start(3);
        wait_idle();
        chk("b2b_done_before", int'(done_o), 1);
        start(5);
        chk("b2b_done_drops", int'(done_o), 0);
        chk("b2b_out_cleared", int'(out_o), 0);
        chk("b2b_busy", int'(busy_o), 1);
        @(negedge clk);
        go_i = 1'b1;
        count_i = 4'd1;
        @(posedge clk);
        #1 go_i = 1'b0;
        @(negedge clk);
        go_i = 1'b1;
        count_i = 4'd7;
        @(posedge clk);
        #1 go_i = 1'b0;
        wait_idle();

        // Reset in the middle of a fill
        start(6);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midfill_rst_out", int'(out_o), 0);
        chk("midfill_rst_busy", int'(busy_o), 0);
        chk("midfill_rst_done", int'(done_o), 0);
        sb.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle_done", int'(done_o), 0);
        chk("post_rst_idle_busy", int'(busy_o), 0);
        start(2);
        wait_idle();

        for (int c = 0; c <= W; c++) begin
            start(c);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("final_done_hold", int'(done_o), 1);
        chk("final_out_hold", int'(out_o), int'(exp_vec(W)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
